// File: rtl/pc_attack_sequencer.sv
// PC turn sequencer for the battleship game: think delay, random/scan cell pick,
// read-check-write of the player board, and end-of-turn pulses for the game FSM.
module pc_attack_sequencer #(
    parameter int ROWS         = 5,
    parameter int COLS         = 5,
    parameter int THINK_CYCLES = 4,
    parameter int MAX_TRIES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_turn,
    input  logic       load,
    input  logic [4:0] load_cells,
    output logic [4:0] mem_addr,
    output logic       mem_rd,
    input  logic [1:0] mem_rdata,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    output logic       pc_move,
    output logic       shot_hit,
    output logic       shot_miss,
    output logic [2:0] last_row,
    output logic [2:0] last_col,
    output logic [4:0] cells_left,
    output logic       busy
);

    localparam int NCELLS = ROWS * COLS;
    localparam int TRW    = $clog2(MAX_TRIES + 1);
    localparam int THW    = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_THINK,
        S_PICK,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             pc_turn_q;
    logic [THW-1:0]   think_q, think_d;
    logic [TRW-1:0]   tries_q, tries_d;
    logic             scan_mode_q, scan_mode_d;
    logic [4:0]       scan_q, scan_d;
    logic [4:0]       addr_q, addr_d;
    logic [1:0]       rdata_q, rdata_d;
    logic [5:0]       shots_q, shots_d;
    logic [4:0]       cells_q, cells_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic             wrote_q, wrote_d;
    logic             hit_q, hit_d;
    logic             pick_ok;
    logic             abort;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running in every state
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign pick_ok = ({1'b0, lfsr_q[4:0]} < 6'(NCELLS));
    assign abort   = !pc_turn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 8'hA5;
            pc_turn_q   <= 1'b0;
            think_q     <= '0;
            tries_q     <= '0;
            scan_mode_q <= 1'b0;
            scan_q      <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            shots_q     <= '0;
            cells_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wrote_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pc_turn_q   <= pc_turn;
            think_q     <= think_d;
            tries_q     <= tries_d;
            scan_mode_q <= scan_mode_d;
            scan_q      <= scan_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            shots_q     <= shots_d;
            cells_q     <= cells_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wrote_q     <= wrote_d;
            hit_q       <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        think_d     = think_q;
        tries_d     = tries_q;
        scan_mode_d = scan_mode_q;
        scan_d      = scan_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        shots_d     = shots_q;
        cells_d     = cells_q;
        row_d       = row_q;
        col_d       = col_q;
        wrote_d     = wrote_q;
        hit_d       = hit_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    cells_d = load_cells;
                    shots_d = '0;
                end
                if (pc_turn && !pc_turn_q) begin
                    state_d     = S_THINK;
                    think_d     = '0;
                    tries_d     = '0;
                    scan_d      = '0;
                    scan_mode_d = 1'b0;
                    wrote_d     = 1'b0;
                    hit_d       = 1'b0;
                end
            end
            S_THINK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (think_q == THW'(THINK_CYCLES - 1)) begin
                    state_d = S_PICK;
                end else begin
                    think_d = think_q + THW'(1);
                end
            end
            S_PICK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (shots_q == 6'(NCELLS)) begin
                    state_d = S_DONE;
                end else if (scan_mode_q) begin
                    addr_d  = scan_q;
                    state_d = S_READ;
                end else if (pick_ok) begin
                    addr_d  = lfsr_q[4:0];
                    state_d = S_READ;
                end
            end
            S_READ: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: state_d = abort ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mem_rdata[1]) begin
                    state_d = S_PICK;
                    if (scan_mode_q) begin
                        // wrap so a stale board cannot walk the scan off the end
                        scan_d = (scan_q == 5'(NCELLS - 1)) ? 5'd0 : scan_q + 5'd1;
                    end else begin
                        tries_d = tries_q + TRW'(1);
                        if (tries_q == TRW'(MAX_TRIES - 1)) begin
                            scan_mode_d = 1'b1;
                        end
                    end
                end else begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                shots_d = shots_q + 6'd1;
                if (rdata_q[0] && (cells_q != 5'd0)) begin
                    cells_d = cells_q - 5'd1;
                end
                row_d   = 3'(addr_q / 5'(COLS));
                col_d   = 3'(addr_q % 5'(COLS));
                wrote_d = 1'b1;
                hit_d   = rdata_q[0];
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_rd     = (state_q == S_READ);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_wdata  = (state_q == S_WRITE) ? {1'b1, rdata_q[0]} : 2'b00;
    assign pc_move    = (state_q == S_DONE);
    assign shot_hit   = (state_q == S_DONE) && wrote_q && hit_q;
    assign shot_miss  = (state_q == S_DONE) && wrote_q && !hit_q;
    assign last_row   = row_q;
    assign last_col   = col_q;
    assign cells_left = cells_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pc_attack_sequencer.sv
// Directed bench for pc_attack_sequencer: board memory model, LFSR reference for
// pick prediction, and turn-level checks of hit, miss, scan, abort, reset and full board.
module tb_pc_attack_sequencer;

    localparam int T  = 4;
    localparam int NC = 25;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       pc_turn    = 1'b0;
    logic       load       = 1'b0;
    logic [4:0] load_cells = 5'd0;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic [1:0] mem_rdata  = 2'b00;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic       pc_move, shot_hit, shot_miss, busy;
    logic [2:0] last_row, last_col;
    logic [4:0] cells_left;

    logic [1:0] mem [0:31];
    logic       fill_en   = 1'b0;
    int         fill_kind = 0;
    logic [7:0] lfsr_m;

    int checks = 0;
    int errors = 0;

    int n_rd, n_we, we_addr, we_data, move_idx, overlap, extra, pred_idx, pred_addr;
    int t_hit, t_miss, t_row, t_col, t_cells;

    pc_attack_sequencer #(.ROWS(5), .COLS(5), .THINK_CYCLES(T), .MAX_TRIES(16)) dut (
        .clk(clk), .rst(rst), .pc_turn(pc_turn), .load(load), .load_cells(load_cells),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .pc_move(pc_move), .shot_hit(shot_hit), .shot_miss(shot_miss),
        .last_row(last_row), .last_col(last_col), .cells_left(cells_left), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] cell_init(input int kind, input int i);
        case (kind)
            1:       return 2'b01;
            2:       return (i < 24) ? 2'b10 : 2'b00;
            3:       return ((i % 6) == 0 && i < NC) ? 2'b01 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= lfsr_next(lfsr_m);
    end

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 32; i++) mem[i] <= cell_init(fill_kind, i);
        end else begin
            if (mem_rd) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int kind);
        fill_kind = kind;
        fill_en   = 1'b1;
        @(negedge clk);
        fill_en   = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] v);
        load       = 1'b1;
        load_cells = v;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic run_turn(input int budget);
        logic [7:0] v;
        int n;
        n_rd = 0; n_we = 0; we_addr = -1; we_data = -1; move_idx = -1;
        overlap = 0; extra = 0; pred_idx = -1; pred_addr = -1;
        t_hit = 0; t_miss = 0; t_row = -1; t_col = -1; t_cells = -1;
        pc_turn = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == T) begin
                v = lfsr_m;
                n = 0;
                while (v[4:0] >= 5'd25 && n < 300) begin
                    v = lfsr_next(v);
                    n++;
                end
                pred_addr = int'(v[4:0]);
                pred_idx  = T + 5 + n;
            end
            if (mem_rd) n_rd++;
            if (mem_we) begin
                n_we++;
                we_addr = int'(mem_addr);
                we_data = int'(mem_wdata);
            end
            if (mem_rd && mem_we) overlap++;
            if (pc_move) begin
                move_idx = i;
                t_hit    = int'(shot_hit);
                t_miss   = int'(shot_miss);
                t_row    = int'(last_row);
                t_col    = int'(last_col);
                t_cells  = int'(cells_left);
                break;
            end
        end
        // pc_turn stays high: no second turn may start
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy || pc_move || mem_rd || mem_we) extra++;
        end
        pc_turn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, seen, tot_we, tot_hit, tot_miss, tot_move, tot_bad, exp_cl, cl_bad;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({pc_move, shot_hit, shot_miss, mem_rd, mem_we}), 0);
        check("rst_cells_left", 32'(cells_left), 0);
        check("rst_last_rc", 32'({last_row, last_col}), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || mem_rd || mem_we) cnt++;
        end
        check("idle_after_reset", 32'(cnt), 0);

        // hit: all ships
        fill(1);
        do_load(5'd17);
        run_turn(300);
        check("hit_move_latency", 32'(move_idx), 32'(pred_idx));
        check("hit_addr", 32'(we_addr), 32'(pred_addr));
        check("hit_we_count", 32'(n_we), 1);
        check("hit_rd_count", 32'(n_rd), 1);
        check("hit_wdata", 32'(we_data), 3);
        check("hit_pulses", 32'({t_hit, t_miss}), 32'({32'd1, 32'd0}));
        check("hit_cells_left", 32'(t_cells), 16);
        check("hit_last_row", 32'(t_row), 32'(pred_addr / 5));
        check("hit_last_col", 32'(t_col), 32'(pred_addr % 5));
        check("hit_mem_written", 32'(mem[pred_addr]), 3);
        check("hit_overlap_extra", 32'(overlap + extra), 0);

        // miss: empty board
        fill(0);
        run_turn(300);
        check("miss_move_latency", 32'(move_idx), 32'(pred_idx));
        check("miss_wdata", 32'(we_data), 2);
        check("miss_pulses", 32'({t_hit, t_miss}), 32'({32'd0, 32'd1}));
        check("miss_cells_left", 32'(t_cells), 16);
        check("miss_rc_vs_addr", 32'(t_row * 5 + t_col), 32'(we_addr));
        check("miss_overlap_extra", 32'(overlap + extra), 0);

        // scan fallback: only cell 24 unattacked
        fill(2);
        run_turn(3000);
        check("scan_moved", 32'(move_idx >= 0), 1);
        check("scan_we_count", 32'(n_we), 1);
        check("scan_addr", 32'(we_addr), 24);
        check("scan_last_rc", 32'({t_row, t_col}), 32'({32'd4, 32'd4}));
        check("scan_miss", 32'({t_hit, t_miss}), 32'({32'd0, 32'd1}));
        check("scan_overlap", 32'(overlap + extra), 0);

        // abort during THINK
        fill(0);
        pc_turn = 1'b1;
        @(negedge clk);
        check("abort_think_busy", 32'(busy), 1);
        @(negedge clk);
        pc_turn = 1'b0;
        @(negedge clk);
        check("abort_think_idle", 32'(busy), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_we || pc_move || mem_rd || busy) cnt++;
        end
        check("abort_think_quiet", 32'(cnt), 0);

        // abort during WAIT
        pc_turn = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_rd) begin
                seen = 1;
                break;
            end
        end
        check("abort_wait_saw_read", 32'(seen), 1);
        @(negedge clk);
        check("abort_wait_state", 32'({busy, mem_rd, mem_we}), 32'(3'b100));
        pc_turn = 1'b0;
        @(negedge clk);
        check("abort_wait_idle", 32'(busy), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_we || pc_move || busy) cnt++;
        end
        check("abort_wait_quiet", 32'(cnt), 0);

        // reset mid-turn
        pc_turn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_we) cnt++;
        end
        rst = 1'b0;
        #1;
        check("midrst_outputs", 32'({busy, pc_move, shot_hit, shot_miss, mem_rd, mem_we}), 0);
        check("midrst_regs", 32'({cells_left, last_row, last_col, mem_addr}), 0);
        pc_turn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy || mem_rd || mem_we) cnt++;
        end
        seen = 0;
        for (int i = 0; i < NC; i++) if (mem[i] != 2'b00) seen++;
        check("midrst_no_activity", 32'(cnt + seen), 0);

        // fill the board: 5 ships, only 2 counted so cells_left saturates
        fill(3);
        do_load(5'd2);
        tot_we = 0; tot_hit = 0; tot_miss = 0; tot_move = 0; tot_bad = 0;
        exp_cl = 2; cl_bad = 0;
        for (int t = 0; t < NC; t++) begin
            run_turn(3000);
            tot_we   += n_we;
            tot_hit  += t_hit;
            tot_miss += t_miss;
            if (move_idx >= 0) tot_move++;
            tot_bad  += overlap + extra + ((n_we != 1) ? 1 : 0);
            if (t_hit != 0 && exp_cl > 0) exp_cl--;
            if (t_cells != exp_cl) cl_bad++;
        end
        check("full_moves", 32'(tot_move), 25);
        check("full_writes", 32'(tot_we), 25);
        check("full_hits", 32'(tot_hit), 5);
        check("full_misses", 32'(tot_miss), 20);
        check("full_turn_anomalies", 32'(tot_bad), 0);
        check("full_cells_left_track", 32'(cl_bad), 0);
        check("full_cells_left_sat", 32'(cells_left), 0);
        cnt = 0;
        for (int i = 0; i < NC; i++) if (mem[i][1]) cnt++;
        check("full_board_attacked", 32'(cnt), 25);

        run_turn(50);
        check("over_move_latency", 32'(move_idx), T + 1);
        check("over_no_access", 32'(n_rd + n_we), 0);
        check("over_no_shot", 32'({t_hit, t_miss}), 0);
        check("over_extra", 32'(extra), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
